// File: rtl/wb_write_buffer.sv
// rtl/wb_write_buffer.sv - in-order regfile write-back buffer with read bypass
// Optional tail-entry coalescing when WB_COALESCE_EN is defined.
module wb_write_buffer #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 4,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_reg,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                drain_en,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   rd_reg1,
  input  logic [ADDR_W-1:0]   rd_reg2,
  output logic                byp_hit1,
  output logic [DATA_W-1:0]   byp_data1,
  output logic                byp_hit2,
  output logic [DATA_W-1:0]   byp_data2,
  output logic [CNT_W-1:0]    count,
  output logic                empty,
  output logic                full
);

  logic [ADDR_W-1:0] ent_reg  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [PTR_W-1:0]  head, tail;
  logic              push, pop, alloc, coal;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign pop   = drain_en && !empty;

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] tail_idx;
  assign tail_idx = tail - PTR_W'(1);
  // The youngest entry may be overwritten unless it is the lone head leaving this cycle.
  assign coal = !empty && (ent_reg[tail_idx] == in_reg) && (in_reg != '0)
                && !(drain_en && count == CNT_W'(1));
`else
  assign coal = 1'b0;
`endif

  assign in_ready = !full || coal;
  assign push     = in_valid && in_ready;
  assign alloc    = push && (in_reg != '0) && !coal;

  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    if (pop) begin
      wr_en[ent_reg[head]] = 1'b1;
      wr_data              = ent_data[head];
    end
  end

  // Walk oldest to youngest so the last match is the newest pending value.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (ent_vld[idx] && rd_reg1 != '0 && ent_reg[idx] == rd_reg1) begin
        byp_hit1  = 1'b1;
        byp_data1 = ent_data[idx];
      end
      if (ent_vld[idx] && rd_reg2 != '0 && ent_reg[idx] == rd_reg2) begin
        byp_hit2  = 1'b1;
        byp_data2 = ent_data[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
`ifdef WB_COALESCE_EN
      if (push && coal)
        ent_data[tail_idx] <= in_data;
`endif
      if (alloc) begin
        ent_vld[tail]  <= 1'b1;
        ent_reg[tail]  <= in_reg;
        ent_data[tail] <= in_data;
        tail           <= tail + PTR_W'(1);
      end
      case ({alloc, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_buffer.sv
// tb/tb_wb_write_buffer.sv - randomized and directed bench for wb_write_buffer
// Reference model is a queue of pending writes.
module tb_wb_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_reg = '0;
  logic [15:0] in_data = '0;
  logic        drain_en = 1'b0;
  logic [15:0] wr_en;
  logic [15:0] wr_data;
  logic [3:0]  rd_reg1 = '0;
  logic [3:0]  rd_reg2 = '0;
  logic        byp_hit1, byp_hit2;
  logic [15:0] byp_data1, byp_data2;
  logic [2:0]  count;
  logic        empty, full;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  r;
    logic [15:0] d;
  } ent_t;
  ent_t q[$];

  wb_write_buffer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .drain_en(drain_en), .wr_en(wr_en), .wr_data(wr_data),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_byp(input logic [3:0] r, output logic hit, output logic [15:0] d);
    hit = 1'b0;
    d   = '0;
    if (r != 0)
      foreach (q[i])
        if (q[i].r == r) begin
          hit = 1'b1;
          d   = q[i].d;
        end
  endfunction

  function automatic logic model_coal(input logic [3:0] r, input logic dr);
`ifdef WB_COALESCE_EN
    return q.size() > 0 && r != 0 && q[q.size()-1].r == r && !(dr && q.size() == 1);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle from a negedge, check all outputs, advance the model at the edge.
  task automatic step(input logic v, input logic [3:0] r, input logic [15:0] d,
                      input logic dr, input logic [3:0] r1, input logic [3:0] r2);
    logic        e_ready, e_push, e_pop, e_coal, h;
    logic [15:0] bd, e_wr_en, e_wr_data;
    in_valid = v; in_reg = r; in_data = d; drain_en = dr; rd_reg1 = r1; rd_reg2 = r2;
    #1;
    e_coal    = model_coal(r, dr);
    e_ready   = (q.size() < DEPTH) || e_coal;
    e_push    = v && e_ready;
    e_pop     = dr && q.size() > 0;
    e_wr_en   = e_pop ? (16'h1 << q[0].r) : 16'h0;
    e_wr_data = e_pop ? q[0].d : 16'h0;
    chk("in_ready", in_ready, e_ready);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("wr_en", wr_en, e_wr_en);
    chk("wr_data", wr_data, e_wr_data);
    model_byp(r1, h, bd);
    chk("byp_hit1", byp_hit1, h);
    chk("byp_data1", byp_data1, bd);
    model_byp(r2, h, bd);
    chk("byp_hit2", byp_hit2, h);
    chk("byp_data2", byp_data2, bd);
    @(posedge clk);
    if (e_push && e_coal) q[q.size()-1].d = d;
    if (e_pop) void'(q.pop_front());
    if (e_push && !e_coal && r != 0) q.push_back('{r: r, d: d});
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_byp_hit1", byp_hit1, 0);
    chk("rst_byp_data1", byp_data1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // asynchronous reset with writes pending
    step(1, 4'd3, 16'h1234, 0, 4'd3, 4'd5);
    step(1, 4'd5, 16'hBEEF, 0, 4'd3, 4'd5);
    chk("pre_rst_count", count, 2);
    #2 rst = 1'b0;
    drain_en = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_byp_hit1", byp_hit1, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(0, 4'd0, 16'h0, 1, 4'd3, 4'd5);
    step(0, 4'd0, 16'h0, 1, 4'd3, 4'd5);

    // in-order drain
    step(1, 4'd1, 16'h0001, 0, 4'd1, 4'd2);
    step(1, 4'd2, 16'h0002, 0, 4'd1, 4'd2);
    step(1, 4'd3, 16'h0003, 0, 4'd1, 4'd2);
    in_valid = 1'b0; drain_en = 1'b1;
    #1;
    chk("ord_wr_en0", wr_en, 16'h0002);
    chk("ord_wr_data0", wr_data, 16'h0001);
    repeat (3) step(0, 4'd0, 16'h0, 1, 4'd3, 4'd1);
    chk("ord_empty", empty, 1);

    // full boundary
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 16'(i * 16'h111), 0, 4'(i), 4'd4);
    chk("full_flag", full, 1);
    chk("full_ready", in_ready, 0);
    step(1, 4'd6, 16'h0666, 0, 4'd6, 4'd1);
    step(0, 4'd0, 16'h0, 1, 4'd6, 4'd1);
    chk("after_drain_count", count, 3);
    chk("after_drain_ready", in_ready, 1);
    repeat (3) step(0, 4'd0, 16'h0, 1, 4'd2, 4'd6);

    // bypass priority
    step(1, 4'd7, 16'hAAAA, 0, 4'd7, 4'd0);
    step(1, 4'd7, 16'h5555, 0, 4'd7, 4'd0);
    rd_reg1 = 4'd7; rd_reg2 = 4'd0; in_valid = 1'b0; drain_en = 1'b0;
    #1;
    chk("byp_prio_hit", byp_hit1, 1);
    chk("byp_prio_data", byp_data1, 16'h5555);
    chk("byp_r0_hit", byp_hit2, 0);
    chk("byp_r0_data", byp_data2, 0);
    repeat (2) step(0, 4'd0, 16'h0, 1, 4'd7, 4'd0);

    // R0 discard, then simultaneous push and drain
    step(1, 4'd1, 16'h0011, 0, 4'd1, 4'd0);
    step(1, 4'd0, 16'hFFFF, 0, 4'd0, 4'd0);
    chk("r0_count", count, 1);
    step(1, 4'd2, 16'h0022, 0, 4'd2, 4'd0);
    step(1, 4'd4, 16'h0044, 1, 4'd4, 4'd1);
    chk("pushpop_count", count, 2);
    repeat (2) step(0, 4'd0, 16'h0, 1, 4'd4, 4'd2);

`ifdef WB_COALESCE_EN
    step(1, 4'd1, 16'h0101, 0, 4'd9, 4'd1);
    step(1, 4'd2, 16'h0202, 0, 4'd9, 4'd1);
    step(1, 4'd3, 16'h0303, 0, 4'd9, 4'd1);
    step(1, 4'd9, 16'h0900, 0, 4'd9, 4'd1);
    chk("coal_full", full, 1);
    step(1, 4'd9, 16'h0999, 0, 4'd9, 4'd1);
    chk("coal_count", count, 4);
    in_valid = 1'b1; in_reg = 4'd10;
    #1;
    chk("coal_miss_ready", in_ready, 0);
    repeat (4) step(0, 4'd0, 16'h0, 1, 4'd9, 4'd3);
`endif

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0,
           4'($urandom_range(0, 5) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 4)),
           16'($urandom),
           $urandom_range(0, 2) == 0,
           4'($urandom_range(0, 5)),
           4'($urandom_range(0, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
